// File: rtl/cache_l2_nway_pkg.sv
// Shared types and sizing helpers for the N-way L2 cache.
//   cache_line     : 128-bit line carried on both mem_* and pmem_* ports
//   lc3b_word      : 16-bit byte address
//   cache_state_e  : controller states (CHECK is the reset state)
//   cache_tag_w()  : tag width for a given log2 set count
//   plru_bits()    : number of tree-PLRU node bits for a given associativity
package cache_l2_nway_pkg;

  typedef logic [127:0] cache_line;
  typedef logic [15:0]  lc3b_word;

  localparam int CACHE_ADDR_W   = 16;
  localparam int CACHE_OFFSET_W = 4;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_e;

  function automatic int cache_tag_w(input int sets_log2);
    return CACHE_ADDR_W - CACHE_OFFSET_W - sets_log2;
  endfunction

  function automatic int plru_bits(input int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/cache_l2_nway_plru_tree.sv
// Tree pseudo-LRU for one set.
//   tree_i       : current node bits (node i has children 2i+1 / 2i+2;
//                  a 0 bit means the victim is in the left subtree)
//   access_way_i : way being accessed this cycle
//   victim_way_o : way the tree currently points at
//   tree_o       : node bits after accessing access_way_i (path flipped
//                  to point at the opposite subtree at every level)
module plru_tree
  import cache_l2_nway_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [plru_bits(WAYS)-1:0] tree_i,
  input  logic [$clog2(WAYS)-1:0]    access_way_i,
  output logic [$clog2(WAYS)-1:0]    victim_way_o,
  output logic [plru_bits(WAYS)-1:0] tree_o
);

  localparam int WAY_W = $clog2(WAYS);

  // Way number bits, MSB first, are the left/right turns taken from the root.
  always_comb begin
    int unsigned node;
    victim_way_o = '0;
    node         = 0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      victim_way_o[WAY_W-1-lvl] = tree_i[node];
      node = 2 * node + (tree_i[node] ? 32'd2 : 32'd1);
    end
  end

  always_comb begin
    int unsigned node;
    logic        dir;
    tree_o = tree_i;
    node   = 0;
    dir    = 1'b0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      dir          = access_way_i[WAY_W-1-lvl];
      tree_o[node] = ~dir;
      node = 2 * node + (dir ? 32'd2 : 32'd1);
    end
  end

endmodule

// File: rtl/cache_l2_nway.sv
// N-way set-associative, write-back, write-allocate L2 cache.
//   clk, rst                : clock, synchronous active-high reset
//   mem_read/mem_write      : line request from the L1 arbiter, held to mem_resp
//   mem_address/mem_wdata   : request address (offset ignored) and write line
//   mem_rdata/mem_resp      : read line and one-cycle completion strobe
//   pmem_read/pmem_write    : physical memory line request, held to pmem_resp
//   pmem_address/pmem_wdata : line-aligned address and victim line
//   pmem_rdata/pmem_resp    : fill line and memory completion strobe
//   hit_count/miss_count    : saturating event counters
module cache_l2_nway
  import cache_l2_nway_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int TAG_W = cache_tag_w(SETS_LOG2);
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int NB    = plru_bits(WAYS);
  localparam int WAY_W = $clog2(WAYS);

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [NB-1:0]    plru_q  [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  cache_line        data_q  [SETS][WAYS];

  cache_state_e state_q, state_d;
  logic [15:0]  hit_count_q, hit_count_d;
  logic [15:0]  miss_count_q, miss_count_d;
  logic         missed_q, missed_d;

  logic [SETS_LOG2-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic                 req;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 inv_found;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     plru_victim;
  logic [WAY_W-1:0]     victim_way;
  logic [NB-1:0]        plru_upd;
  logic                 victim_dirty;

  logic plru_we;
  logic hit_wr_we;
  logic fill_we;

  logic unused_offset;
  assign unused_offset = ^mem_address[CACHE_OFFSET_W-1:0];

  assign idx = mem_address[CACHE_OFFSET_W +: SETS_LOG2];
  assign tag = mem_address[CACHE_ADDR_W-1 -: TAG_W];
  assign req = mem_read | mem_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  plru_tree #(
    .WAYS(WAYS)
  ) u_plru (
    .tree_i      (plru_q[idx]),
    .access_way_i(hit_way),
    .victim_way_o(plru_victim),
    .tree_o      (plru_upd)
  );

  // The set is not touched while a miss is outstanding, so the victim
  // recomputed every cycle stays the same through WRITEBACK and ALLOCATE.
  assign victim_way   = inv_found ? inv_way : plru_victim;
  assign victim_dirty = valid_q[idx][victim_way] & dirty_q[idx][victim_way];

  assign mem_rdata  = data_q[idx][hit_way];
  assign pmem_wdata = data_q[idx][victim_way];
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    missed_d     = missed_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag, idx, 4'h0};
    plru_we      = 1'b0;
    hit_wr_we    = 1'b0;
    fill_we      = 1'b0;
    unique case (state_q)
      CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            plru_we   = 1'b1;
            hit_wr_we = mem_write;
            missed_d  = 1'b0;
            // The hit that completes a refilled request is not a new hit.
            if (!missed_q && (hit_count_q != '1)) begin
              hit_count_d = hit_count_q + 16'd1;
            end
          end else begin
            missed_d = 1'b1;
            if (miss_count_q != '1) begin
              miss_count_d = miss_count_q + 16'd1;
            end
            state_d = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx][victim_way], idx, 4'h0};
        if (pmem_resp) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_we = 1'b1;
          state_d = CHECK;
        end
      end
      default: begin
        state_d = CHECK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CHECK;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      missed_q     <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      missed_q     <= missed_d;
      if (plru_we) begin
        plru_q[idx] <= plru_upd;
      end
      if (hit_wr_we) begin
        data_q[idx][hit_way]  <= mem_wdata;
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (fill_we) begin
        data_q[idx][victim_way]  <= pmem_rdata;
        tag_q[idx][victim_way]   <= tag;
        valid_q[idx][victim_way] <= 1'b1;
        dirty_q[idx][victim_way] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_l2_nway.sv
module tb_cache_l2_nway;

  localparam int WAYS      = 4;
  localparam int SETS_LOG2 = 3;
  localparam int NRAND     = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count, miss_count;

  cache_l2_nway #(
    .WAYS     (WAYS),
    .SETS_LOG2(SETS_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit           chk;
    logic [127:0] exp;
  } rsp_t;
  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } pm_t;

  rsp_t rsp_q[$];
  pm_t  pm_q[$];

  // model_mem: what a reader must observe; phys_mem: what the memory holds.
  logic [127:0] model_mem[int];
  logic [127:0] phys_mem[int];

  bit chk_pmem = 1'b0;
  bit hold_mem = 1'b0;
  int exp_hits   = 0;
  int exp_misses = 0;

  function automatic logic [127:0] dflt(input int line);
    logic [15:0] l;
    l = 16'(line);
    return {8{l ^ 16'h5A00}};
  endfunction

  function automatic logic [127:0] model_rd(input logic [15:0] a);
    int l;
    l = int'(a[15:4]);
    return model_mem.exists(l) ? model_mem[l] : dflt(l);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_pm(input bit wr, input logic [15:0] a, input logic [127:0] d);
    pm_t e;
    e.wr = wr; e.addr = a; e.data = d;
    pm_q.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every mem_resp.
  always @(negedge clk) begin
    if (!rst && mem_resp) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_mem_resp: actual=1 required=0");
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        if (r.chk) chk("mem_rdata", mem_rdata, r.exp);
      end
    end
  end

  // Physical memory with random latency.
  initial begin
    int lat;
    lat        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) begin
        checks++;
        failures++;
        $display("FAIL pmem_both_high: actual=1 required=0");
      end
      if (rst || hold_mem || !(pmem_read || pmem_write)) begin
        lat = $urandom_range(0, 2);
      end else if (lat > 0) begin
        lat--;
      end else begin
        int  line;
        line = int'(pmem_address[15:4]);
        chk("pmem_addr_align", pmem_address[3:0], 4'h0);
        if (chk_pmem) begin
          if (pm_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pmem: actual=%0h required=none", pmem_address);
          end else begin
            pm_t e;
            e = pm_q.pop_front();
            chk("pmem_write_kind", pmem_write, e.wr);
            chk("pmem_address", pmem_address, e.addr);
            if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
          end
        end
        if (pmem_write) phys_mem[line] = pmem_wdata;
        else pmem_rdata = phys_mem.exists(line) ? phys_mem[line] : dflt(line);
        pmem_resp = 1'b1;
        lat = $urandom_range(0, 2);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completing edge.
  // exp_hit: 1 hit, 0 miss, -1 not predicted.
  task automatic do_req(input logic [15:0] a, input bit rd, input bit wr,
                        input logic [127:0] wd, input int exp_hit);
    rsp_t r;
    int   cyc;
    bit   got;
    r.chk = rd && !wr;
    r.exp = model_rd(a);
    rsp_q.push_back(r);
    if (wr) model_mem[int'(a[15:4])] = wd;
    mem_address = a;
    mem_read    = rd;
    mem_write   = wr;
    mem_wdata   = wd;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
      else cyc++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: actual=no_resp required=resp addr=%0h", a);
      rsp_q.delete();
    end
    if (exp_hit == 1) chk("hit_latency", cyc, 0);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (exp_hit >= 0) begin
      if (exp_hit == 1) exp_hits = sat_inc(exp_hits);
      else exp_misses = sat_inc(exp_misses);
      chk("hit_count", hit_count, exp_hits);
      chk("miss_count", miss_count, exp_misses);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int tot0, tot1;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    phys_mem[32'h123]  = 128'hA5;
    model_mem[32'h123] = 128'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp", mem_resp, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_hit_count", hit_count, 16'h0);
    chk("rst_miss_count", miss_count, 16'h0);
    rst = 1'b0;

    // Directed: fill set 3, tree-PLRU order, dirty eviction and refetch.
    chk_pmem = 1'b1;
    exp_pm(0, 16'h1230, '0);      do_req(16'h1230, 1, 0, '0, 0);
    do_req(16'h1230, 1, 0, '0, 1);
    do_req(16'h1230, 0, 1, 128'h77, 1);
    exp_pm(0, 16'h1A30, '0);      do_req(16'h1A30, 1, 0, '0, 0);
    exp_pm(0, 16'h2230, '0);      do_req(16'h2230, 1, 0, '0, 0);
    exp_pm(0, 16'h2A30, '0);      do_req(16'h2A30, 1, 0, '0, 0);
    do_req(16'h1230, 1, 0, '0, 1);
    exp_pm(0, 16'h3230, '0);      do_req(16'h3230, 1, 0, '0, 0);
    do_req(16'h1A30, 1, 0, '0, 1);
    do_req(16'h2A30, 1, 0, '0, 1);
    exp_pm(1, 16'h1230, 128'h77);
    exp_pm(0, 16'h4230, '0);      do_req(16'h4230, 1, 0, '0, 0);
    exp_pm(0, 16'h2230, '0);      do_req(16'h2230, 1, 0, '0, 0);
    exp_pm(0, 16'h1230, '0);      do_req(16'h1230, 1, 0, '0, 0);
    chk("pmem_exp_drained", pm_q.size(), 0);
    chk_pmem = 1'b0;

    // Random traffic over two sets, data checked against model memory.
    tot0 = int'(hit_count) + int'(miss_count);
    for (int n = 0; n < NRAND; n++) begin
      logic [15:0] a;
      int          op;
      a  = {7'(0), 2'($urandom_range(0, 5)), 7'(0)};
      a  = 16'(($urandom_range(0, 5) << 7) | ($urandom_range(0, 1) << 4) | $urandom_range(0, 15));
      op = $urandom_range(0, 3);
      do_req(a, op != 2, op >= 2, {$urandom, $urandom, $urandom, $urandom}, -1);
    end
    tot1 = int'(hit_count) + int'(miss_count);
    chk("random_req_total", tot1 - tot0, NRAND);

    // Reset during the second ALLOCATE cycle.
    hold_mem    = 1'b1;
    mem_address = 16'h5230;
    mem_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("alloc_pmem_read", pmem_read, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("rst_alloc_pmem_read", pmem_read, 1'b0);
    chk("rst_alloc_pmem_write", pmem_write, 1'b0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    hold_mem   = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    rsp_q.delete();
    model_mem  = phys_mem;
    chk_pmem   = 1'b1;
    exp_pm(0, 16'h5230, '0);      do_req(16'h5230, 1, 0, '0, 0);
    exp_pm(0, 16'h1230, '0);      do_req(16'h1230, 1, 0, '0, 0);
    chk("pmem_exp_drained2", pm_q.size(), 0);

    // Hit counter saturation.
    force dut.hit_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count_q;
    @(posedge clk);
    #1;
    exp_hits = 65534;
    repeat (3) do_req(16'h5230, 1, 0, '0, 1);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_l2_nway.md
# cache_l2_nway

Parametrised N-way set-associative, write-back, write-allocate L2 cache for the LC-3b memory hierarchy. It sits between the L1 arbiter (line-granular `mem_*` port) and physical memory (`pmem_*` port). Datapath and controller are merged in one block. The block generalises the fixed 2-way/8-set L2 datapath with these additions:
- configurable way and set count;
- tree pseudo-LRU replacement;
- invalid-way-first victim selection;
- synchronous invalidation on reset;
- saturating hit/miss counters.

## Interface
Parameters:
- `WAYS`, 2: associativity; power of two, 2..8.
- `SETS_LOG2`, 3: log2 of set count; 1..6.

Derived field widths:
- Offset: 4 bits (16-byte `cache_line`).
- Index: `SETS_LOG2` bits.
- Tag: `12-SETS_LOG2` bits.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `mem_read`  in  1  line read request; held until `mem_resp`.
- `mem_write`  in  1  line write request; held until `mem_resp`.
- `mem_address`  in  16  byte address (`lc3b_word`); offset bits ignored.
- `mem_wdata`  in  128  write line.
- `mem_rdata`  out  128  read line; valid when `mem_resp` is high.
- `mem_resp`  out  1  one-cycle completion strobe.
- `pmem_read`  out  1  memory line read; held until `pmem_resp`.
- `pmem_write`  out  1  memory line write; held until `pmem_resp`.
- `pmem_address`  out  16  line-aligned address (low 4 bits zero).
- `pmem_wdata`  out  128  victim line.
- `pmem_rdata`  in  128  fill line; valid with `pmem_resp`.
- `pmem_resp`  in  1  memory completion strobe.
- `hit_count`  out  16  saturating hit counter.
- `miss_count`  out  16  saturating miss counter.

## Operation
State per set:
- Per way: `valid`, `dirty`, `tag`, `data`.
- Per set: `WAYS-1` PLRU tree bits.

Arrays are registers and read asynchronously by index. Reset clears all `valid`, `dirty` and PLRU bits, and both counters. Data and tag contents are don't-care after reset.

Request rules:
- Both `mem_read` and `mem_write` high: treated as a write.
- A requester may change address or data only after `mem_resp`.

FSM states are `CHECK` (reset state), `WRITEBACK`, `ALLOCATE`.

`CHECK`:
- Hit means some way has `valid` set and a matching tag.
- On a hit with a request:
  - assert `mem_resp`;
  - drive `mem_rdata` from the hit way;
  - on a write, load `mem_wdata` into the hit way and set `dirty`;
  - update PLRU to point away from the hit way;
  - increment `hit_count` only if this request has not already missed.
- On a miss: increment `miss_count` once, then go to `WRITEBACK` if the victim is valid and dirty, else to `ALLOCATE`.

Victim selection: the lowest-numbered invalid way; if every way is valid, the way selected by PLRU.

`WRITEBACK`:
- Assert `pmem_write` with `pmem_address = {victim tag, index, 4'h0}` and `pmem_wdata` = victim data.
- On `pmem_resp`, go to `ALLOCATE`.

`ALLOCATE`:
- Assert `pmem_read` with `pmem_address = {tag, index, 4'h0}`.
- On `pmem_resp`, load `pmem_rdata` into the victim way: tag written, `valid`=1, `dirty`=0. Then go to `CHECK`, where the request completes as a hit.

PLRU rules:
- Node `i` has children `2i+1` and `2i+2`.
- A node bit of 0 means the victim lies in the left subtree.
- On an access, every bit along the accessed way's path is set to point to the opposite subtree.
- With `WAYS=2` this is exactly 1-bit LRU.

## Timing
- Reset values: `mem_resp`, `pmem_read`, `pmem_write` = 0; both counters = 0; state = `CHECK`.
- `mem_resp` on a hit is combinational in the same cycle as the request (zero wait states). Array and PLRU updates take effect on that edge.
- Clean miss: 1 cycle in `CHECK`, then `ALLOCATE` until `pmem_resp`, then 1 cycle `CHECK` with `mem_resp`. `mem_resp` therefore comes one cycle after `pmem_resp`.
- Dirty miss: adds the `WRITEBACK` phase before `ALLOCATE`.
- `pmem_read`/`pmem_write` deassert in the cycle after the `pmem_resp` edge; never both high.
- `pmem_resp` is ignored in `CHECK`.
- Counters saturate at 16'hFFFF.
- Reset mid-`WRITEBACK`/`ALLOCATE`: return to `CHECK` and deassert `pmem_*` the next cycle. The fill in progress is discarded and the set is invalidated.

## Structure
- `cache_types` gains:
  - the `cache_line` (128-bit) typedef;
  - `CACHE_OFFSET_W = 4`;
  - helper functions `cache_tag_w(SETS_LOG2)` and `plru_bits(WAYS)`.
- One sub-module, `plru_tree`, parametrised by `WAYS`:
  - input: current tree bits;
  - outputs: victim way, and updated bits for a given accessed way.
- Tag compare and FSM are in the top level.

## Test plan
- Reset, read `0x1230` (`WAYS=2`) → `pmem_read` with address `0x1230`; return `128'hA5`; `mem_resp` one cycle later with `mem_rdata=128'hA5`; `miss_count=1`. Repeat read → same-cycle `mem_resp`, `hit_count=1`.
- Write `0x1230` with `128'h77` (hit) → `dirty` set. Read `0x1A30`, then `0x2230` (same set, 2-way) → `pmem_write` to `0x1230` with data `128'h77` precedes `pmem_read` of `0x2230`.
- `WAYS=4`, set 3: fill tags 0..3 in order, then hit on way 0. The next miss must evict way 2 per tree order. Check `pmem_address` on the following eviction.
- Invalid-first: after reset, four misses to the same set fill ways 0,1,2,3 in order with no `pmem_write`.
- Assert `rst` in the 2nd cycle of `ALLOCATE` → `pmem_read`=0 next cycle. Re-reading the same address misses again.
- Force `hit_count` to 16'hFFFE, then issue 3 hits → count holds at 16'hFFFF.
